seqfifo_sched: RTL and testbench
================================

# seqfifo_sched

Single-clock scheduler that shares one address/sequence generator between two requesters, for example the scanline fetch and the host/blitter port of the VGA pipeline. Each requester asks for a burst, described by a start word and a length. The block arbitrates round-robin, then emits the arithmetic sequence Start, Start+STRIDE, … with a valid/ready handshake. It tags every beat with its owner and signals completion per requester.

## Interface
- `WWIDTH`, 8, width of the sequence word (address).
- `IWIDTH`, 4, index width; length ports are IWIDTH+1 bits.
- `BUFSIZE`, 16, maximum burst length; requested lengths above it are clamped.
- `STRIDE`, 1, increment between consecutive beats.

Ports:
- `Clk`  in  1  single clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Req0`, `Req1`  in  1  burst request; held until the matching Grant is seen.
- `Start0`, `Start1`  in  WWIDTH  first word of the burst; stable while Req is high.
- `Len0`, `Len1`  in  IWIDTH+1  beat count; stable while Req is high.
- `Grant0`, `Grant1`  out  1  one-cycle pulse: the request was latched.
- `DataOut`  out  WWIDTH  current sequence word.
- `DataValid`  out  1  DataOut holds a beat.
- `DataReady`  in  1  the consumer accepts the beat when DataValid && DataReady.
- `DataLast`  out  1  the current beat is the final beat of the burst.
- `Owner`  out  1  requester index of the current burst.
- `Done0`, `Done1`  out  1  one-cycle pulse after the burst completes.
- `Busy`  out  1  state is not IDLE.

## Operation
- States: IDLE, RUN, GAP. All outputs are registered.
- Reset (async) forces:
  - state to IDLE;
  - all outputs to 0, so DataOut=0 and Owner=0;
  - round-robin pointer LastOwner to 1, so Req0 wins the first tie.
- IDLE, arbitration:
  - Only Req0 high: pick 0. Only Req1 high: pick 1.
  - Both high: pick !LastOwner.
  - On the clock edge after picking:
    - latch Start and effective length L = min(Len, BUFSIZE);
    - set Owner and LastOwner to the pick;
    - pulse Grant<pick> for one cycle.
  - L>0: go to RUN with DataOut=Start and DataValid=1; DataLast=1 iff L==1.
  - L==0: go to GAP without producing beats. Grant and Done pulse in the same cycle.
- RUN, beats:
  - A beat is accepted when DataValid && DataReady.
  - Non-final accepted beat: DataOut <= DataOut + STRIDE, computed modulo 2^WWIDTH (wraps silently); remaining count decrements.
  - DataLast=1 exactly when remaining==1.
  - Final accepted beat: DataValid=0, DataLast=0, go to GAP.
  - DataReady=0: stall; DataOut, DataValid and DataLast hold.
  - Req inputs are ignored in RUN.
- GAP: pulse Done<Owner> for one cycle, then go to IDLE. Req inputs are ignored in GAP.
- Requesters must drop Req in the cycle after Grant is seen. A Req still high in IDLE is treated as a new request.

## Timing
- Grant-to-data latency is 0.
  - Request sampled in IDLE at cycle T.
  - Grant, Busy=1 and the first DataValid beat all appear in cycle T+1.
- With DataReady held at 1, an L-beat burst occupies cycles T+1..T+L.
  - Done in T+L+1; IDLE in T+L+2.
  - The next burst's first beat appears at T+L+3 at the earliest. There is one dead arbitration cycle between bursts.
- Len=0: Grant and Done both in T+1; IDLE in T+2.
- Busy is 1 in RUN and GAP, and 0 in IDLE.
- Reset asserted mid-burst: all outputs clear immediately (asynchronously). No Done is issued; the aborted burst is lost.
- Req changes during RUN/GAP have no effect until IDLE.

## Test plan
- **Reset:** assert Reset mid-RUN with DataOut=0x05 -> all outputs read 0 within the same cycle. After release with Req0=Req1=1, Grant0 fires first.
- **Single burst:** Req0, Start0=0x10, Len0=4, DataReady=1 -> Grant0 and 0x10 in the next cycle. Beats are 0x10, 0x11, 0x12, 0x13, with DataLast on 0x13. Done0 one cycle later; Busy drops the cycle after that.
- **Round-robin:** both requests permanently high (re-raised after Grant), Len=2 -> Owner sequence 0,1,0,1. Exactly one idle cycle sits between each Done and the next Grant.
- **Backpressure:** Len1=3, Start1=0x20, DataReady toggled 1,0,0,1,1 -> accepted beats are 0x20, 0x21, 0x22. DataOut holds 0x21 through both stall cycles; Done1 follows the 0x22 acceptance.
- **Wrap and clamp:** Start0=0xFE, Len0=20 (BUFSIZE=16) -> 16 beats, 0xFE, 0xFF, 0x00 … 0x0D, with DataLast on 0x0D.
- **Zero length:** Req1, Len1=0 -> Grant1 and Done1 in the same cycle. DataValid stays 0; state is back to IDLE two cycles after the request is sampled.

Source files
------------

// File: rtl/seqfifo_sched.sv
// Round-robin scheduler sharing one arithmetic sequence generator between two
// burst requesters; emits Start, Start+STRIDE, ... with a valid/ready handshake.
module seqfifo_sched #(
    parameter int WWIDTH  = 8,
    parameter int IWIDTH  = 4,
    parameter int BUFSIZE = 16,
    parameter int STRIDE  = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              Req1,
    input  logic [WWIDTH-1:0] Start0,
    input  logic [WWIDTH-1:0] Start1,
    input  logic [IWIDTH:0]   Len0,
    input  logic [IWIDTH:0]   Len1,
    output logic              Grant0,
    output logic              Grant1,
    output logic [WWIDTH-1:0] DataOut,
    output logic              DataValid,
    input  logic              DataReady,
    output logic              DataLast,
    output logic              Owner,
    output logic              Done0,
    output logic              Done1,
    output logic              Busy,
    output logic [1:0]        State
);

    // Handshake: a beat transfers on any rising Clk where DataValid && DataReady;
    // DataOut/DataValid/DataLast hold while DataReady is low.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [IWIDTH:0] MAX_LEN = (IWIDTH + 1)'(BUFSIZE);
    localparam logic [IWIDTH:0] LEN_ONE = (IWIDTH + 1)'(1);
    localparam logic [IWIDTH:0] LEN_TWO = (IWIDTH + 1)'(2);
    localparam logic [IWIDTH:0] LEN_ZERO = '0;

    state_t            state_q, next_state;
    logic [IWIDTH:0]   rem_q, rem_d;
    logic              last_owner_q, last_owner_d;
    logic [WWIDTH-1:0] data_d;
    logic              valid_d, last_d, owner_d;
    logic              grant0_d, grant1_d, done0_d, done1_d, busy_d;

    logic              pick;
    logic [IWIDTH:0]   len_sel, eff_len;
    logic              accept;

    // Both requesting: alternate away from the previous winner.
    assign pick    = (Req0 && Req1) ? ~last_owner_q : Req1;
    assign len_sel = pick ? Len1 : Len0;
    assign eff_len = (len_sel > MAX_LEN) ? MAX_LEN : len_sel;
    assign accept  = DataValid && DataReady;
    assign State   = state_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            last_owner_q <= 1'b1;
            DataOut      <= '0;
            DataValid    <= 1'b0;
            DataLast     <= 1'b0;
            Owner        <= 1'b0;
            Grant0       <= 1'b0;
            Grant1       <= 1'b0;
            Done0        <= 1'b0;
            Done1        <= 1'b0;
            Busy         <= 1'b0;
        end else begin
            state_q      <= next_state;
            rem_q        <= rem_d;
            last_owner_q <= last_owner_d;
            DataOut      <= data_d;
            DataValid    <= valid_d;
            DataLast     <= last_d;
            Owner        <= owner_d;
            Grant0       <= grant0_d;
            Grant1       <= grant1_d;
            Done0        <= done0_d;
            Done1        <= done1_d;
            Busy         <= busy_d;
        end
    end

    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE: begin
                if (Req0 || Req1) begin
                    next_state = (eff_len == LEN_ZERO) ? GAP : RUN;
                end
            end
            RUN: begin
                if (accept && rem_q == LEN_ONE) begin
                    next_state = GAP;
                end
            end
            GAP:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        data_d       = DataOut;
        valid_d      = DataValid;
        last_d       = DataLast;
        owner_d      = Owner;
        last_owner_d = last_owner_q;
        rem_d        = rem_q;
        grant0_d     = 1'b0;
        grant1_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (Req0 || Req1) begin
                    data_d       = pick ? Start1 : Start0;
                    rem_d        = eff_len;
                    valid_d      = (eff_len != LEN_ZERO);
                    last_d       = (eff_len == LEN_ONE);
                    owner_d      = pick;
                    last_owner_d = pick;
                    grant0_d     = ~pick;
                    grant1_d     = pick;
                end
            end
            RUN: begin
                if (accept) begin
                    if (rem_q == LEN_ONE) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        data_d = DataOut + WWIDTH'(STRIDE);
                        rem_d  = rem_q - LEN_ONE;
                        last_d = (rem_q == LEN_TWO);
                    end
                end
            end
            default: ;
        endcase
        // GAP lasts one cycle, so Done pulses exactly on entry.
        done0_d = (next_state == GAP) && !owner_d;
        done1_d = (next_state == GAP) && owner_d;
        busy_d  = (next_state != IDLE);
    end

endmodule

// File: tb/tb_seqfifo_sched.sv
// Directed bench for seqfifo_sched: reset, single burst, backpressure,
// wrap/clamp, zero length, mid-burst reset and round-robin alternation.
module tb_seqfifo_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] start0, start1;
    logic [4:0] len0, len1;
    logic       grant0, grant1;
    logic [7:0] data_out;
    logic       data_valid, data_ready, data_last;
    logic       owner, done0, done1, busy;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    seqfifo_sched dut (
        .Clk(clk), .Reset(reset),
        .Req0(req0), .Req1(req1),
        .Start0(start0), .Start1(start1),
        .Len0(len0), .Len1(len1),
        .Grant0(grant0), .Grant1(grant1),
        .DataOut(data_out), .DataValid(data_valid), .DataReady(data_ready),
        .DataLast(data_last), .Owner(owner),
        .Done0(done0), .Done1(done1), .Busy(busy), .State(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_data"},  32'(data_out), 0);
        check({tag, "_valid"}, 32'(data_valid), 0);
        check({tag, "_last"},  32'(data_last), 0);
        check({tag, "_owner"}, 32'(owner), 0);
        check({tag, "_grant"}, 32'({grant1, grant0}), 0);
        check({tag, "_done"},  32'({done1, done0}), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_state"}, 32'(state), 0);
    endtask

    logic       bp_ready[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] bp_data[5]  = '{8'h20, 8'h21, 8'h21, 8'h21, 8'h22};
    logic       bp_last[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        reset = 1'b1; req0 = 0; req1 = 0;
        start0 = '0; start1 = '0; len0 = '0; len1 = '0; data_ready = 1'b0;
        tick();
        tick();
        check_cleared("reset");
        reset = 1'b0;
        tick();

        // Single burst from requester 0
        req0 = 1; start0 = 8'h10; len0 = 5'd4; data_ready = 1;
        tick();
        check("single_grant0", 32'(grant0), 1);
        check("single_grant1", 32'(grant1), 0);
        check("single_busy", 32'(busy), 1);
        check("single_owner", 32'(owner), 0);
        req0 = 0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("single_data%0d", i), 32'(data_out), 32'h10 + i);
            check($sformatf("single_valid%0d", i), 32'(data_valid), 1);
            check($sformatf("single_last%0d", i), 32'(data_last), (i == 3) ? 1 : 0);
            tick();
        end
        check("single_done0", 32'(done0), 1);
        check("single_done1", 32'(done1), 0);
        check("single_valid_off", 32'(data_valid), 0);
        check("single_gap_busy", 32'(busy), 1);
        tick();
        check("single_idle_busy", 32'(busy), 0);
        check("single_done_pulse", 32'(done0), 0);

        // Backpressure on requester 1
        req1 = 1; start1 = 8'h20; len1 = 5'd3;
        tick();
        check("bp_grant1", 32'(grant1), 1);
        check("bp_owner", 32'(owner), 1);
        req1 = 0;
        for (int i = 0; i < 5; i++) begin
            data_ready = bp_ready[i];
            check($sformatf("bp_data%0d", i), 32'(data_out), 32'(bp_data[i]));
            check($sformatf("bp_valid%0d", i), 32'(data_valid), 1);
            check($sformatf("bp_last%0d", i), 32'(data_last), 32'(bp_last[i]));
            tick();
        end
        check("bp_done1", 32'(done1), 1);
        check("bp_done0", 32'(done0), 0);
        check("bp_valid_off", 32'(data_valid), 0);
        tick();
        check("bp_idle", 32'(busy), 0);

        // Wrap-around plus length clamp to 16 beats
        data_ready = 1; req0 = 1; start0 = 8'hFE; len0 = 5'd20;
        tick();
        check("wrap_grant0", 32'(grant0), 1);
        req0 = 0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("wrap_data%0d", i), 32'(data_out), 32'(8'(8'hFE + i)));
            check($sformatf("wrap_last%0d", i), 32'(data_last), (i == 15) ? 1 : 0);
            tick();
        end
        check("wrap_done0", 32'(done0), 1);
        check("wrap_valid_off", 32'(data_valid), 0);
        tick();
        check("wrap_idle", 32'(busy), 0);

        // Zero length on requester 1
        req1 = 1; start1 = 8'h33; len1 = 5'd0;
        tick();
        check("zero_grant1", 32'(grant1), 1);
        check("zero_done1", 32'(done1), 1);
        check("zero_valid", 32'(data_valid), 0);
        check("zero_busy", 32'(busy), 1);
        req1 = 0;
        tick();
        check("zero_idle_busy", 32'(busy), 0);
        check("zero_idle_state", 32'(state), 0);
        check("zero_done_pulse", 32'(done1), 0);

        // Mid-burst reset while DataOut is 0x05
        req0 = 1; start0 = 8'h03; len0 = 5'd8;
        tick();
        req0 = 0;
        tick();
        tick();
        check("midrst_data_before", 32'(data_out), 32'h05);
        reset = 1'b1;
        #1;
        check_cleared("midrst");
        req0 = 1; req1 = 1; start0 = 8'h40; start1 = 8'h80; len0 = 5'd2; len1 = 5'd2;
        tick();
        reset = 1'b0;
        tick();

        // Round-robin with both requests held high
        for (int b = 0; b < 4; b++) begin
            check($sformatf("rr%0d_grant0", b), 32'(grant0), (b % 2 == 0) ? 1 : 0);
            check($sformatf("rr%0d_grant1", b), 32'(grant1), (b % 2 == 1) ? 1 : 0);
            check($sformatf("rr%0d_owner", b), 32'(owner), b % 2);
            check($sformatf("rr%0d_beat0", b), 32'(data_out), (b % 2 == 0) ? 32'h40 : 32'h80);
            tick();
            check($sformatf("rr%0d_beat1", b), 32'(data_out), (b % 2 == 0) ? 32'h41 : 32'h81);
            check($sformatf("rr%0d_last", b), 32'(data_last), 1);
            tick();
            check($sformatf("rr%0d_done", b), 32'({done1, done0}), (b % 2 == 0) ? 1 : 2);
            tick();
            check($sformatf("rr%0d_idle_busy", b), 32'(busy), 0);
            check($sformatf("rr%0d_idle_grant", b), 32'({grant1, grant0}), 0);
            tick();
        end
        req0 = 0; req1 = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
